instruction_encoder: RTL and testbench

//  Inverse of immediate decode: packs decoded fields (opcode, funct3/7, rd/rs1/rs2, 32-bit immediate)

---
 rtl/instruction_encoder.sv | 117 +++++++++++
 tb/tb_instruction_encoder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// RV32I field-to-word encoder feeding a FIFO_DEPTH output queue; optional range check via IMM_RANGE_CHECK_EN.
// Latency 1 cycle (push to head, no bypass); in_ready = !full, registered, so a pop does not reopen it that cycle.
module instruction_encoder #(
    parameter int FIFO_DEPTH  = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             instruction_type,
    input  logic [6:0]             opcode,
    input  logic [2:0]             funct3,
    input  logic [6:0]             funct7,
    input  logic [4:0]             rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [31:0]            immediate,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            instruction,
    output logic                   out_error,
    output logic [COUNT_WIDTH-1:0] encode_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [2:0] R_TYPE = 3'd0;
    localparam logic [2:0] I_TYPE = 3'd1;
    localparam logic [2:0] S_TYPE = 3'd2;
    localparam logic [2:0] B_TYPE = 3'd3;
    localparam logic [2:0] U_TYPE = 3'd4;
    localparam logic [2:0] J_TYPE = 3'd5;

    logic [31:0]      enc_word;
    logic             enc_err;
    logic             range_bad;
    logic [32:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [31:0]      last_word;
    logic             last_err;
    logic             full, empty, push, pop;

    always_comb begin
        enc_word = 32'h0000_0013;
        enc_err  = 1'b0;
        case (instruction_type)
            R_TYPE: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            I_TYPE: enc_word = {immediate[11:0], rs1, funct3, rd, opcode};
            S_TYPE: enc_word = {immediate[11:5], rs2, rs1, funct3, immediate[4:0], opcode};
            B_TYPE: enc_word = {immediate[12], immediate[10:5], rs2, rs1, funct3,
                                immediate[4:1], immediate[11], opcode};
            U_TYPE: enc_word = {immediate[31:12], rd, opcode};
            J_TYPE: enc_word = {immediate[20], immediate[10:1], immediate[11],
                                immediate[19:12], rd, opcode};
            default: begin
                enc_word = 32'h0000_0013;
                enc_err  = 1'b1;
            end
        endcase
        enc_err = enc_err | range_bad;
    end

    // Immediate must survive truncation to the field width of its format.
    always_comb begin
        range_bad = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        case (instruction_type)
            I_TYPE, S_TYPE: range_bad = !((&immediate[31:11]) || (~|immediate[31:11]));
            B_TYPE: range_bad = !((&immediate[31:12]) || (~|immediate[31:12])) || immediate[0];
            J_TYPE: range_bad = !((&immediate[31:20]) || (~|immediate[31:20])) || immediate[0];
            U_TYPE: range_bad = |immediate[11:0];
            default: range_bad = 1'b0;
        endcase
`endif
    end

    assign full      = (occ == OCC_W'(FIFO_DEPTH));
    assign empty     = (occ == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // With the queue empty the outputs hold the last word handed off.
    assign instruction = empty ? last_word : mem[rd_ptr][31:0];
    assign out_error   = empty ? last_err  : mem[rd_ptr][32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            last_word    <= '0;
            last_err     <= 1'b0;
            encode_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {enc_err, enc_word};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_word <= mem[rd_ptr][31:0];
                last_err  <= mem[rd_ptr][32];
                if (encode_count != '1) encode_count <= encode_count + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_encoder.sv
// Directed-vector bench for instruction_encoder; expected error bits follow IMM_RANGE_CHECK_EN.
module tb_instruction_encoder;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [2:0]  instruction_type;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] immediate;
    logic        out_valid, out_ready;
    logic [31:0] instruction;
    logic        out_error;
    logic [15:0] encode_count;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    instruction_encoder #(.FIFO_DEPTH(2), .COUNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction_type(instruction_type), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .immediate(immediate),
        .out_valid(out_valid), .out_ready(out_ready),
        .instruction(instruction), .out_error(out_error), .encode_count(encode_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_fields(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] imm);
        instruction_type = t; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; immediate = imm;
    endtask

    // Push one bundle, expect it at the head one cycle later, pop it, expect held outputs.
    task automatic encode_one(input string tag, input logic [2:0] t, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] imm,
                              input logic [31:0] exp_word, input logic exp_err);
        set_fields(t, op, f3, f7, d, s1, s2, imm);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_word"}, instruction, exp_word);
        check({tag, "_err"}, 32'(out_error), 32'(exp_err));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_empty"}, 32'(out_valid), 32'd0);
        check({tag, "_hold"}, instruction, exp_word);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_instruction", instruction, 32'd0);
        check("rst_out_error", 32'(out_error), 32'd0);
        check("rst_count", 32'(encode_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #2;
        do_reset();

        encode_one("i_neg1", 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        encode_one("b_8",    3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_8463, 1'b0);
        encode_one("b_9",    3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd9,         32'h0020_8463, RC);
        encode_one("j_800",  3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800,       32'h0010_00EF, 1'b0);
        encode_one("i_800",  3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h800,       32'h8000_0013, RC);
        encode_one("r_sub",  3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF, 32'h4031_00B3, 1'b0);
        encode_one("s_sw",   3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'h24,        32'h0251_2223, 1'b0);
        encode_one("u_lui",  3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        encode_one("u_low",  3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h1234_52B7, RC);
        encode_one("illegal",3'd6, 7'h33, 3'd1, 7'h7F, 5'd7, 5'd7, 5'd7, 32'd0,        32'h0000_0013, 1'b1);
        check("count_after_vectors", 32'(encode_count), 32'd10);

        // Fill the depth-2 queue with the consumer stalled; the third bundle must wait.
        do_reset();
        set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("fill_a_ready", 32'(in_ready), 32'd1);
        immediate = 32'd2;
        @(posedge clk); #1;
        check("fill_b_full", 32'(in_ready), 32'd0);
        immediate = 32'd3;
        @(posedge clk); #1;
        check("fill_c_held", 32'(in_ready), 32'd0);
        check("fill_head_a", instruction, 32'h0010_0093);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("pop_a_head_b", instruction, 32'h0020_0093);
        check("pop_a_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pop_b_head_c", instruction, 32'h0030_0093);
        check("pop_b_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pop_c_empty", 32'(out_valid), 32'd0);
        check("pop_c_hold", instruction, 32'h0030_0093);
        check("pop_count3", 32'(encode_count), 32'd3);

        // Asynchronous reset mid-cycle with two entries queued.
        in_valid = 1'b1;
        immediate = 32'd4;
        @(posedge clk); #1;
        immediate = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_full", 32'(in_ready), 32'd0);
        check("mid_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(encode_count), 32'd0);
        check("mid_rst_word", instruction, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
